// File: rtl/lab2v1_writer_pkg.sv
// Shared constants and types for the byte-stream-to-RAM writer: CSR offsets,
// CTRL/STATUS bit positions, FSM states and the lane geometry of a RAM word.
package lab2v1_writer_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  localparam logic [1:0] CSR_BASE = 2'd0;
  localparam logic [1:0] CSR_LEN  = 2'd1;
  localparam logic [1:0] CSR_CTRL = 2'd2;
  localparam logic [1:0] CSR_CSUM = 2'd3;

  // CTRL write: GO / IRQ_EN / DONE-clear.  STATUS read: BUSY / IRQ_EN / DONE.
  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_DONE   = 2;
  localparam int STAT_BUSY   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/lab2v1_byte_stream_writer_if.sv
// Bus bundle of the writer: CSR slave, byte-stream sink and RAM master port.
// The slave modport is the writer itself, master is the surrounding system.
interface lab2v1_byte_stream_writer_if #(
  parameter int ADDR_W = 14
);

  logic [1:0]        csr_address;
  logic              csr_write;
  logic              csr_read;
  logic [31:0]       csr_writedata;
  logic [31:0]       csr_readdata;

  logic [7:0]        snk_data;
  logic              snk_valid;
  logic              snk_ready;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;

  logic              irq;

  modport slave (
    input  csr_address, csr_write, csr_read, csr_writedata,
    input  snk_data, snk_valid,
    output csr_readdata, snk_ready,
    output mem_address, mem_chipselect, mem_write, mem_writedata,
    output mem_byteenable, mem_clken, irq
  );

  modport master (
    output csr_address, csr_write, csr_read, csr_writedata,
    output snk_data, snk_valid,
    input  csr_readdata, snk_ready,
    input  mem_address, mem_chipselect, mem_write, mem_writedata,
    input  mem_byteenable, mem_clken, irq
  );

endinterface

// File: rtl/lab2v1_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and presents each
// completed (or final partial) word for exactly one cycle after its last byte.
module lab2v1_byte_packer
  import lab2v1_writer_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic             byte_last,
  input  logic [7:0]       byte_data,
  output logic [31:0]      word_data,
  output logic [LANES-1:0] word_be,
  output logic             word_valid
);

  logic [LANE_W-1:0] lane_q;
  logic [31:0]       asm_q;
  logic [31:0]       asm_d;
  logic [LANES-1:0]  be_d;
  logic              word_done;

  // Lane 0 starts a fresh word so unfilled upper lanes of a partial word read as zero.
  always_comb begin
    asm_d = (lane_q == '0) ? 32'd0 : asm_q;
    asm_d[8*int'(lane_q) +: 8] = byte_data;
    be_d = '0;
    for (int i = 0; i < LANES; i++) begin
      be_d[i] = (i <= int'(lane_q));
    end
    word_done = byte_valid & ((lane_q == LANE_W'(LANES-1)) | byte_last);
  end

  // The output word is a separate register so the next byte can land in
  // lane 0 while the previous word is still on the RAM bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q     <= '0;
      asm_q      <= '0;
      word_data  <= '0;
      word_be    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_done;
      if (clear) begin
        lane_q <= '0;
        asm_q  <= '0;
      end else if (byte_valid) begin
        lane_q <= lane_q + LANE_W'(1);
        asm_q  <= asm_d;
      end
      if (word_done) begin
        word_data <= asm_d;
        word_be   <= be_d;
      end
    end
  end

endmodule

// File: rtl/lab2v1_byte_stream_writer.sv
// Byte stream to 32-bit on-chip RAM writer with a CSR slave and done interrupt.
// Optional checksum at CSR 3 is built only when LAB2V1_WRITER_CSUM_EN is defined.
module lab2v1_byte_stream_writer
  import lab2v1_writer_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int DEPTH_WORDS = 10000,
  parameter int LEN_W       = 16
) (
  input logic                        clk,
  input logic                        reset_n,
  lab2v1_byte_stream_writer_if.slave bus
);

  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  byte_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] start_addr;
  logic              irq_en_q;
  logic              done_q;
  logic [31:0]       readdata_q;
  logic [31:0]       rd_mux;
  logic [31:0]       csum_rd;

  logic              busy;
  logic              fill;
  logic              flush;
  logic              wr_base;
  logic              wr_len;
  logic              wr_ctrl;
  logic              go;
  logic              accept;
  logic              last_accept;
  logic              done_set;

  logic [31:0]       word_data;
  logic [3:0]        word_be;
  logic              word_valid;
  logic              unused_wdata;

  assign unused_wdata = ^bus.csr_writedata;

  assign wr_base     = bus.csr_write & (bus.csr_address == CSR_BASE);
  assign wr_len      = bus.csr_write & (bus.csr_address == CSR_LEN);
  assign wr_ctrl     = bus.csr_write & (bus.csr_address == CSR_CTRL);
  assign go          = wr_ctrl & bus.csr_writedata[CTRL_GO] & ~busy;
  assign accept      = bus.snk_valid & fill;
  assign last_accept = accept & (byte_cnt_q == len_q - LEN_W'(1));
  assign done_set    = flush | (go & (len_q == '0));
  assign start_addr  = ({1'b0, base_q} >= DEPTH_V) ? '0 : base_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go && len_q != '0) state_d = FILL;
      FILL:    if (last_accept)       state_d = FLUSH;
      FLUSH:                          state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    fill  = (state_q == FILL);
    flush = (state_q == FLUSH);
  end

  // DONE set (end of flush or zero-length GO) takes priority over both clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (wr_base && !busy) base_q <= bus.csr_writedata[ADDR_W-1:0];
      if (wr_len && !busy)  len_q  <= bus.csr_writedata[LEN_W-1:0];
      if (wr_ctrl)          irq_en_q <= bus.csr_writedata[CTRL_IRQ_EN];
      if (done_set) begin
        done_q <= 1'b1;
      end else if (go || (wr_ctrl && bus.csr_writedata[CTRL_DONE])) begin
        done_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      if (go) begin
        byte_cnt_q <= '0;
      end else if (accept) begin
        byte_cnt_q <= byte_cnt_q + LEN_W'(1);
      end
      if (go) begin
        addr_q <= start_addr;
      end else if (word_valid) begin
        addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      end
    end
  end

`ifdef LAB2V1_WRITER_CSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (go) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q + 16'(bus.snk_data);
    end
  end

  assign csum_rd = 32'(csum_q);
`else
  assign csum_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    unique case (bus.csr_address)
      CSR_BASE: rd_mux = 32'(base_q);
      CSR_LEN:  rd_mux = 32'(len_q);
      CSR_CTRL: begin
        rd_mux[STAT_BUSY]   = busy;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
        rd_mux[CTRL_DONE]   = done_q;
        rd_mux[31:16]       = 16'(byte_cnt_q);
      end
      CSR_CSUM: rd_mux = csum_rd;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (bus.csr_read) begin
      readdata_q <= rd_mux;
    end
  end

  lab2v1_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (go),
    .byte_valid (accept),
    .byte_last  (last_accept),
    .byte_data  (bus.snk_data),
    .word_data  (word_data),
    .word_be    (word_be),
    .word_valid (word_valid)
  );

  assign bus.csr_readdata   = readdata_q;
  assign bus.snk_ready      = fill;
  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = word_valid;
  assign bus.mem_write      = word_valid;
  assign bus.mem_writedata  = word_data;
  assign bus.mem_byteenable = word_be;
  assign bus.mem_clken      = 1'b1;
  assign bus.irq            = done_q & irq_en_q;

endmodule

// File: doc/lab2v1_byte_stream_writer.md
# lab2v1_byte_stream_writer

Upstream feeder for the 32-bit on-chip RAM (`onchip_memory2_0`, port s1). It accepts an 8-bit byte stream, typically from a UART or a loader, and packs the bytes little-endian into 32-bit words. It writes each word into the RAM through a fixed-latency Avalon-MM master, starting at a programmable word address. A small CSR slave lets the Nios II start a transfer, poll for completion and take an interrupt.

## Interface
- `ADDR_W`, 14: RAM word-address width.
- `DEPTH_WORDS`, 10000: RAM depth; the write address wraps at this value.
- `LEN_W`, 16: transfer length width, in bytes.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `csr_address` in 2: CSR word select.
- `csr_write` in 1: CSR write strobe.
- `csr_read` in 1: CSR read strobe.
- `csr_writedata` in 32: CSR write data.
- `csr_readdata` out 32: registered; valid the cycle after `csr_read`.
- `snk_data` in 8: stream byte.
- `snk_valid` in 1: byte valid.
- `snk_ready` out 1: byte accepted when `snk_valid & snk_ready`.
- `mem_address` out ADDR_W: RAM word address.
- `mem_chipselect` out 1: RAM select.
- `mem_write` out 1: one-cycle write strobe.
- `mem_writedata` out 32: packed word.
- `mem_byteenable` out 4: valid byte lanes.
- `mem_clken` out 1: tied to 1.
- `irq` out 1: `done & irq_en`.

## Operation
- CSR map:
  - 0 BASE[ADDR_W-1:0], word address.
  - 1 LEN[LEN_W-1:0], byte count.
  - 2 CTRL/STATUS.
    - Write: bit0 GO, bit1 IRQ_EN (stored), bit2 writes 1 to clear DONE.
    - Read: bit0 BUSY, bit1 IRQ_EN, bit2 DONE, [31:16] bytes accepted.
  - 3 CHECKSUM (see Configuration).
- Writes to BASE or LEN while BUSY are ignored.
- GO while BUSY is ignored.
- GO clears DONE, the byte count, the lane counter and the checksum.
- FSM states are IDLE, FILL and FLUSH.
  - IDLE to FILL on GO with LEN≠0.
  - GO with LEN=0 sets DONE the next cycle and stays in IDLE; no RAM write.
  - FILL: `snk_ready`=1; each accepted byte goes into lane `lane_cnt`, which increments mod 4.
  - On the 4th lane, or on the final byte, the word is registered for a write; byteenable covers the filled lanes (final byte in lane k gives `4'b` with bits 0..k set).
  - FILL to FLUSH on acceptance of byte LEN.
  - FLUSH issues the final write, then goes to IDLE, sets DONE and clears BUSY.
- Address: starts at BASE and increments after each write.
  - `DEPTH_WORDS-1` wraps to 0.
  - BASE ≥ DEPTH_WORDS is treated as 0.
- Arithmetic:
  - Byte counter is LEN_W bits and never exceeds LEN.
  - Address is computed with a compare-and-reset, not a modulo.

## Timing
- Reset values: all outputs 0 except `mem_clken`=1; FSM in IDLE; DONE, IRQ_EN and all CSRs at 0.
- Byte accepted at cycle N that completes a word: `mem_write`=`mem_chipselect`=1 at N+1 for exactly one cycle. Address, data and byteenable are stable in that cycle.
- Sustained throughput is 1 byte per cycle, with no stall: the RAM has no waitrequest.
- Last byte accepted at N: final write at N+1, BUSY=0 and DONE=1 at N+2, `irq` at N+2 if IRQ_EN.
- `snk_ready` is combinational from state only (high iff FILL). It is low from N+1 after the last byte.
- A DONE clear (W1C) and DONE set in the same cycle: the set wins.
- Reset mid-transfer aborts immediately. A pending partial word is discarded and not written.

## Configuration
- `LAB2V1_WRITER_CSUM_EN` defined:
  - 16-bit running sum (mod 2^16) of accepted bytes, cleared by GO.
  - Readable at CSR 3 in [15:0].
- Undefined: CSR 3 reads 0 and no checksum logic is built.

## Structure
- Package `lab2v1_writer_pkg` holds:
  - CSR offsets.
  - CTRL bit positions.
  - FSM state enum.
  - `LANES`=4.
- Sub-module `lab2v1_byte_packer` owns the lane counter, the 32-bit assembly register, byteenable generation and the word-ready pulse.
- The top level owns the CSRs, the FSM, address/wrap and the RAM master.

## Test plan
- BASE=0x10, LEN=8, bytes 01..08 back-to-back: writes of 0x04030201 @0x10 and 0x08070605 @0x11, BE=F both times. DONE at 2 cycles after the last byte.
- LEN=6, bytes AA..AF: second write 0x0000AFAE @BASE+1 with BE=0x3. Status [31:16]=6.
- BASE=9999, LEN=8: writes go to 9999 then 0.
- LEN=0 with GO: DONE next cycle, `mem_write` never asserted. IRQ_EN=1 gives `irq`=1; writing CTRL bit2 drops it.
- GO while BUSY, and BASE written while BUSY: both ignored and the transfer is unchanged. Reset asserted after 2 bytes: no RAM write, all outputs return to their reset values.
- `LAB2V1_WRITER_CSUM_EN`, bytes FF×4: CSR3 reads 0x03FC. Without the macro: CSR3 reads 0.
